// File: rtl/pla_b4_z_capture.sv
// pla_b4_z_capture
// Capture stage behind the b4 PLA decoder. It samples the decoder's z vector
// on in_valid and can drop a vector equal to the last one accepted. Accepted
// vectors go into a small first-word-fall-through FIFO that is read with a
// valid/ready handshake. A vector lost because the FIFO is full sets a sticky
// overflow flag and increments a saturating drop counter.
module pla_b4_z_capture #(
  parameter int WIDTH = 23,
  parameter int DEPTH = 4,
  parameter int DEDUP = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           z_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic [7:0]                 drop_cnt,
  input  logic                       clr_ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0]    rd_ptr_reg, wr_ptr_reg;
  logic [LW-1:0]    level_reg, level_next;
  logic             overflow_reg, overflow_next;
  logic [7:0]       drop_cnt_reg, drop_cnt_next;
  logic [WIDTH-1:0] last_reg;
  logic             have_last_reg;

  logic is_empty, is_full, is_dup, pop, push, drop;

  assign is_empty = (level_reg == '0);
  assign is_full  = (level_reg == LW'(DEPTH));
  // The duplicate filter only compares against vectors that were actually
  // queued, so a vector lost on overflow can be re-sent and accepted.
  assign is_dup   = (DEDUP != 0) && have_last_reg && (z_in == last_reg);
  assign pop      = !is_empty && out_ready;
  // When the FIFO is full, a pop in the same cycle frees the slot for the push.
  assign push     = in_valid && !is_dup && (!is_full || pop);
  assign drop     = in_valid && !is_dup && is_full && !pop;

  assign out_valid = !is_empty;
  assign out_data  = is_empty ? '0 : mem[rd_ptr_reg];
  assign level     = level_reg;
  assign overflow  = overflow_reg;
  assign drop_cnt  = drop_cnt_reg;

  // Next occupancy and loss accounting; a drop takes priority over clr_ovf.
  always_comb begin
    level_next    = level_reg;
    overflow_next = overflow_reg;
    drop_cnt_next = drop_cnt_reg;
    case ({push, pop})
      2'b10:   level_next = level_reg + LW'(1);
      2'b01:   level_next = level_reg - LW'(1);
      default: level_next = level_reg;
    endcase
    if (drop) begin
      overflow_next = 1'b1;
      if (clr_ovf)
        drop_cnt_next = 8'd1;
      else if (drop_cnt_reg != 8'hFF)
        drop_cnt_next = drop_cnt_reg + 8'd1;
    end else if (clr_ovf) begin
      overflow_next = 1'b0;
      drop_cnt_next = 8'd0;
    end
  end

  // Storage has no reset; the entries are not visible while level is 0.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= z_in;
  end

  // Pointers, occupancy, overflow accounting and the last-accepted vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      level_reg     <= '0;
      overflow_reg  <= 1'b0;
      drop_cnt_reg  <= 8'd0;
      last_reg      <= '0;
      have_last_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg    <= wr_ptr_reg + PW'(1);
        last_reg      <= z_in;
        have_last_reg <= 1'b1;
      end
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      level_reg    <= level_next;
      overflow_reg <= overflow_next;
      drop_cnt_reg <= drop_cnt_next;
    end
  end

endmodule

// File: tb/tb_pla_b4_z_capture.sv
// Directed testbench for pla_b4_z_capture. It runs two instances on the same
// stimulus, one with DEDUP=0 (d0) and one with DEDUP=1 (d1).
module tb_pla_b4_z_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [22:0] z_in = '0;
  logic        out_ready = 1'b0;
  logic        clr_ovf = 1'b0;

  logic        v0, v1, ov0, ov1;
  logic [22:0] d0, d1;
  logic [2:0]  l0, l1;
  logic [7:0]  c0, c1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pla_b4_z_capture #(.WIDTH(23), .DEPTH(4), .DEDUP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .z_in(z_in),
    .out_valid(v0), .out_ready(out_ready), .out_data(d0), .level(l0),
    .overflow(ov0), .drop_cnt(c0), .clr_ovf(clr_ovf));

  pla_b4_z_capture #(.WIDTH(23), .DEPTH(4), .DEDUP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .z_in(z_in),
    .out_valid(v1), .out_ready(out_ready), .out_data(d1), .level(l1),
    .overflow(ov1), .drop_cnt(c1), .clr_ovf(clr_ovf));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [22:0] v);
    in_valid = 1'b1;
    z_in = v;
    tick();
    in_valid = 1'b0;
    $display("push z=%06h  d0 lvl=%0d  d1 lvl=%0d", v, l0, l1);
  endtask

  task automatic pop0(input logic [22:0] v);
    chk("pop.valid", {31'd0, v0}, 32'd1);
    chk("pop.data", {9'd0, d0}, {9'd0, v});
    $display("pop  d0 z=%06h", d0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    clr_ovf = 1'b0;
    tick();
    rst_n = 1'b1;
    $display("reset");
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst.valid", {31'd0, v0}, 32'd0);
    chk("rst.data", {9'd0, d0}, 32'd0);
    chk("rst.level", {29'd0, l0}, 32'd0);
    chk("rst.ovf", {31'd0, ov0}, 32'd0);
    chk("rst.cnt", {24'd0, c0}, 32'd0);
    rst_n = 1'b1;

    // Single push, visible after one edge, then reset in the middle of the hold
    push(23'h5A5A5A);
    chk("single.valid", {31'd0, v0}, 32'd1);
    chk("single.data", {9'd0, d0}, 32'h5A5A5A);
    chk("single.level", {29'd0, l0}, 32'd1);
    tick();
    chk("hold.data", {9'd0, d0}, 32'h5A5A5A);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.valid", {31'd0, v0}, 32'd0);
    chk("midrst.level", {29'd0, l0}, 32'd0);
    chk("midrst.data", {9'd0, d0}, 32'd0);
    tick();
    rst_n = 1'b1;

    // Fill 1..6 with no reader: two vectors are lost
    for (int i = 1; i <= 6; i++) push(23'(i));
    chk("fill.level", {29'd0, l0}, 32'd4);
    chk("fill.ovf", {31'd0, ov0}, 32'd1);
    chk("fill.cnt", {24'd0, c0}, 32'd2);
    for (int i = 1; i <= 4; i++) pop0(23'(i));
    chk("drain.valid", {31'd0, v0}, 32'd0);
    chk("drain.data", {9'd0, d0}, 32'd0);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("clr.ovf", {31'd0, ov0}, 32'd0);
    chk("clr.cnt", {24'd0, c0}, 32'd0);

    // Push and pop in the same cycle while full
    for (int i = 1; i <= 4; i++) push(23'(i));
    out_ready = 1'b1;
    push(23'd9);
    out_ready = 1'b0;
    chk("pp.level", {29'd0, l0}, 32'd4);
    chk("pp.ovf", {31'd0, ov0}, 32'd0);
    pop0(23'd2);
    pop0(23'd3);
    pop0(23'd4);
    pop0(23'd9);
    chk("pp.empty", {31'd0, v0}, 32'd0);

    // Duplicate filter: 7,7,7 then 8,7
    do_reset();
    push(23'd7);
    push(23'd7);
    push(23'd7);
    chk("dd.l0", {29'd0, l0}, 32'd3);
    chk("dd.l1", {29'd0, l1}, 32'd1);
    chk("dd.d1", {9'd0, d1}, 32'd7);
    pop0(23'd7);
    chk("dd.d1empty", {31'd0, v1}, 32'd0);
    pop0(23'd7);
    pop0(23'd7);
    push(23'd8);
    push(23'd7);
    chk("dd.l0b", {29'd0, l0}, 32'd2);
    chk("dd.l1b", {29'd0, l1}, 32'd2);
    chk("dd.d1b", {9'd0, d1}, 32'd8);
    pop0(23'd8);
    chk("dd.d1c", {9'd0, d1}, 32'd7);
    pop0(23'd7);
    chk("dd.c1", {24'd0, c1}, 32'd0);
    chk("dd.ov1", {31'd0, ov1}, 32'd0);

    // Drop counter saturation, then clear with and without a concurrent drop
    do_reset();
    for (int i = 1; i <= 4; i++) push(23'(i));
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      z_in = 23'(100 + i);
      tick();
    end
    chk("sat.cnt0", {24'd0, c0}, 32'd255);
    chk("sat.ovf0", {31'd0, ov0}, 32'd1);
    chk("sat.cnt1", {24'd0, c1}, 32'd255);
    chk("sat.level", {29'd0, l0}, 32'd4);
    clr_ovf = 1'b1;
    z_in = 23'h1234;
    tick();
    chk("clrdrop.cnt", {24'd0, c0}, 32'd1);
    chk("clrdrop.ovf", {31'd0, ov0}, 32'd1);
    in_valid = 1'b0;
    tick();
    clr_ovf = 1'b0;
    chk("clr2.cnt", {24'd0, c0}, 32'd0);
    chk("clr2.ovf", {31'd0, ov0}, 32'd0);
    $display("saturation and clear done");

    // Streaming with out_ready held high: one vector per cycle, latency 1
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      z_in = 23'(i);
      tick();
      chk("stream.valid", {31'd0, v0}, 32'd1);
      chk("stream.data", {9'd0, d0}, 32'(i));
      chk("stream.level", {29'd0, l0}, 32'd1);
      chk("stream.d1", {9'd0, d1}, 32'(i));
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    chk("stream.end", {31'd0, v0}, 32'd0);
    chk("stream.ovf", {31'd0, ov0}, 32'd0);
    $display("streaming done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
